mtc_sl_tx_buffer: RTL
=====================

// Module: mtc_sl_tx_buffer
// PURPOSE
//  Downstream of the MTC builder. Takes up to N_IN MTC2SL words per clock (MSB = valid) and buffers them in a multi-write FIFO.
//  Drains the FIFO as one word per clock onto the sector-logic TX link, using a valid/ready handshake.
//  Words are emitted in arrival order; within a cycle, lowest input index goes first.
//  Overflowing words are dropped and counted; the block never stalls upstream.
// PARAMETERS
//  MTC_WIDTH   MTC2SL_LEN  width of one MTC word; bit MTC_WIDTH-1 is the valid flag
//  N_IN        3           parallel input words per clock (= n_PRIMARY_MTC)
//  FIFO_DEPTH  8           buffer entries; power of 2, >= N_IN
//  CNT_WIDTH   16          width of the drop counter
// PORTS
//  clock       in   1                          system clock
//  rst         in   1                          synchronous, active-high reset
//  srst        in   1                          synchronous soft reset; same effect as rst
//  mtc_in      in   [MTC_WIDTH-1:0] x N_IN     MTC words from builder; entry valid when MSB = 1
//  sl_ready    in   1                          link accepts sl_data this cycle
//  sl_valid    out  1                          sl_data holds a word
//  sl_data     out  MTC_WIDTH                  head word; MSB always 1 while sl_valid
//  fifo_level  out  $clog2(FIFO_DEPTH+1)       current occupancy, excluding the output register
//  level_hwm   out  $clog2(FIFO_DEPTH+1)       highest fifo_level since reset
//  drop_count  out  CNT_WIDTH                  words dropped; saturates at all-ones
//  overflow    out  1                          sticky; set on the first drop
// BEHAVIOUR
//  - Reset (rst | srst, sampled at posedge): next cycle every output = 0; pointers, count and hwm = 0.
//  - Reset mid-operation discards all buffered words, and any word held in sl_data, without handshake.
//  - Write side, per cycle:
//    nvld = popcount of the input MSBs.
//    free = FIFO_DEPTH - fifo_level + pop, where pop is this cycle's FIFO read.
//    The first min(nvld, free) valid inputs, in ascending index order, are written at consecutive slots from wr_ptr.
//    Invalid inputs leave no gap.
//  - Drop: ndrop = nvld - written. drop_count += ndrop, saturating. If ndrop > 0, overflow <= 1.
//  - Read side:
//    pop = (fifo_level != 0) && (!sl_valid || sl_ready).
//    On pop, sl_data <= mem[rd_ptr] and sl_valid <= 1.
//    If there is no pop and sl_valid && sl_ready, then sl_valid <= 0 and sl_data <= 0.
//  - Handshake: while sl_valid && !sl_ready, sl_data and sl_valid hold stable.
//  - Throughput: one word per cycle with sl_ready held high.
//  - Occupancy: fifo_level_next = fifo_level + written - pop.
//    Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//    Simultaneous write and pop on the same slot is legal: pop reads the old head, not the newly written word.
//  - Latency: a word presented in cycle c into an empty buffer with sl_valid = 0 appears on sl_data in cycle c+2.
//  - Full FIFO with sl_ready = 1: the popped slot is reusable in the same cycle, so up to 1 word is accepted.
//  - hwm: level_hwm <= max(level_hwm, fifo_level_next).
//  - No bypass path; the input never reaches sl_data combinationally.
// STRUCTURE
//  - Shared package mtc_sl_tx_pkg holds:
//    - typedef mtc2sl_word_t (logic [MTC2SL_LEN-1:0]);
//    - function popcount_valid(), taking input MSBs and returning a count;
//    - localparam MTC2SL_VALID_BIT = MTC2SL_LEN-1.
//    The bus constants come from l0mdt_buses_constants.svh.
//  - Sub-module mtc_mw_fifo: N_IN-write, 1-read register-array FIFO with compaction and a level output.
//    The top level adds the output register, the handshake and the counters.
// TESTING
//  - T1 single word: mtc_in[1] = {1,X} in cycle 0, sl_ready = 1 -> sl_valid = 1 with sl_data = {1,X} in cycle 2 only; drop_count = 0.
//  - T2 ordering: cycle 0 inputs {A, -, C}, cycle 1 inputs {D, E, F}, sl_ready = 1 -> link sees A, C, D, E, F on consecutive cycles 2-6.
//  - T3 backpressure: fill with 5 words, hold sl_ready = 0 for 10 cycles -> sl_data frozen on word 1; fifo_level = 4.
//    Release -> words 1-5 delivered in order, none lost.
//  - T4 overflow: sl_ready = 0, three valid inputs per cycle for 4 cycles (DEPTH 8) -> fifo_level = 8, drop_count = 3, overflow = 1, level_hwm = 8.
//    Note: first word sits in sl_data, so 9 are stored in total.
//  - T5 full with pop: FIFO full, sl_ready = 1, 3 valid inputs -> first input accepted, drop_count += 2, fifo_level stays 8.
//  - T6 reset mid-burst: assert srst for 1 cycle while sl_valid = 1 and fifo_level = 6.
//    -> next cycle all outputs 0; a new word afterwards appears after 2 cycles.

Source files
------------

// File: rtl/mtc_sl_tx_pkg.sv
// Shared types and helpers for the MTC to sector-logic TX path.
package mtc_sl_tx_pkg;

    // Mirrors MTC2SL_LEN from the l0mdt bus constants header.
    localparam int MTC2SL_LEN       = 32;
    localparam int MTC2SL_VALID_BIT = MTC2SL_LEN - 1;
    localparam int MAX_N_IN         = 8;

    typedef logic [MTC2SL_LEN-1:0] mtc2sl_word_t;

    function automatic int popcount_valid(input logic [MAX_N_IN-1:0] msbs);
        int n;
        n = 0;
        for (int i = 0; i < MAX_N_IN; i++) n += int'(msbs[i]);
        return n;
    endfunction

endpackage

// File: rtl/mtc_sl_tx_buffer_fifo.sv
// N_IN-write, 1-read register FIFO; valid inputs are compacted into consecutive slots.
module mtc_mw_fifo
    import mtc_sl_tx_pkg::*;
#(
    parameter int WIDTH = MTC2SL_LEN,
    parameter int N_IN  = 3,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [N_IN-1:0][WIDTH-1:0] wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [LW-1:0]              level,
    output logic [LW-1:0]              n_valid,
    output logic [LW-1:0]              n_written
);

    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [WIDTH-1:0]         mem [DEPTH];
    logic [N_IN-1:0]          vld;
    logic [N_IN-1:0]          we;
    logic [N_IN-1:0][PW-1:0]  slot;
    int                       nvld;
    int                       nfree;
    int                       nwr;
    int                       rank;

    // A pop frees its slot this cycle, so a full FIFO can still take one word.
    always_comb begin
        vld   = '0;
        we    = '0;
        slot  = '0;
        rank  = 0;
        for (int i = 0; i < N_IN; i++) vld[i] = wr_data[i][WIDTH-1];
        nvld  = popcount_valid(MAX_N_IN'(vld));
        nfree = DEPTH - int'(level) + int'(pop);
        nwr   = (nvld < nfree) ? nvld : nfree;
        for (int i = 0; i < N_IN; i++) begin
            slot[i] = wr_ptr + PW'(rank);
            we[i]   = vld[i] && (rank < nwr);
            rank    = rank + int'(vld[i]);
        end
    end

    assign n_valid   = LW'(nvld);
    assign n_written = LW'(nwr);
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_IN; i++)
            if (we[i]) mem[slot[i]] <= wr_data[i];
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(nwr);
            rd_ptr <= rd_ptr + PW'(pop);
            level  <= LW'(int'(level) + nwr - int'(pop));
        end
    end

endmodule

// File: rtl/mtc_sl_tx_buffer.sv
// Buffers up to N_IN MTC words per clock and drains them one per clock onto the SL TX link.
module mtc_sl_tx_buffer
    import mtc_sl_tx_pkg::*;
#(
    parameter int MTC_WIDTH  = MTC2SL_LEN,
    parameter int N_IN       = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           srst,
    input  logic [N_IN-1:0][MTC_WIDTH-1:0] mtc_in,
    input  logic                           sl_ready,
    output logic                           sl_valid,
    output logic [MTC_WIDTH-1:0]           sl_data,
    output logic [LW-1:0]                  fifo_level,
    output logic [LW-1:0]                  level_hwm,
    output logic [CNT_WIDTH-1:0]           drop_count,
    output logic                           overflow
);

    localparam int DSW = CNT_WIDTH + 1;

    logic                 clr;
    logic                 pop;
    logic [MTC_WIDTH-1:0] head;
    logic [LW-1:0]        n_valid;
    logic [LW-1:0]        n_written;
    logic [LW-1:0]        n_drop;
    logic [LW-1:0]        level_next;
    logic [DSW-1:0]       drop_sum;

    assign clr        = rst | srst;
    assign pop        = (fifo_level != '0) && (!sl_valid || sl_ready);
    assign n_drop     = n_valid - n_written;
    assign level_next = fifo_level + n_written - LW'(pop);
    assign drop_sum   = {1'b0, drop_count} + DSW'(n_drop);

    mtc_mw_fifo #(
        .WIDTH (MTC_WIDTH),
        .N_IN  (N_IN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst       (clr),
        .wr_data   (mtc_in),
        .pop       (pop),
        .rd_data   (head),
        .level     (fifo_level),
        .n_valid   (n_valid),
        .n_written (n_written)
    );

    always_ff @(posedge clock) begin
        if (clr) begin
            sl_valid   <= 1'b0;
            sl_data    <= '0;
            level_hwm  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                sl_valid <= 1'b1;
                sl_data  <= head;
            end else if (sl_valid && sl_ready) begin
                sl_valid <= 1'b0;
                sl_data  <= '0;
            end
            if (level_next > level_hwm) level_hwm <= level_next;
            if (n_drop != '0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
            end
        end
    end

endmodule
